// File: rtl/rc4_prga_reader_if.sv
// Memory-side bus of the RC4 PRGA reader: S memory, encrypted ROM and decrypted RAM.
interface rc4_prga_reader_if #(
    parameter int S_AW = 8,
    parameter int M_AW = 5
);
    logic [S_AW-1:0] s_addr;
    logic [7:0]      s_data;
    logic            s_wren;
    logic [7:0]      s_q;
    logic [M_AW-1:0] rom_addr;
    logic [7:0]      rom_q;
    logic [M_AW-1:0] out_addr;
    logic [7:0]      out_data;
    logic            out_wren;

    modport master (
        output s_addr, s_data, s_wren, rom_addr, out_addr, out_data, out_wren,
        input  s_q, rom_q
    );

    modport slave (
        input  s_addr, s_data, s_wren, rom_addr, out_addr, out_data, out_wren,
        output s_q, rom_q
    );
endinterface

// File: rtl/rc4_prga_reader.sv
// RC4 PRGA stage: swaps S entries, XORs keystream with the encrypted ROM into the output RAM.
// Optional RC4_PRGA_CHECK_PRINTABLE_EN aborts on the first byte outside 'a'..'z' and space.
module rc4_prga_reader #(
    parameter int MSG_LEN = 32,
    parameter int S_AW    = 8,
    parameter int M_AW    = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               valid,
    rc4_prga_reader_if.master  mem
);
    typedef enum logic [3:0] {
        IDLE, INC_I, RD_I, WT_I, LT_I, RD_J, WT_J, LT_J,
        WR_I, WR_J, RD_F, WT_F, WR_O, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [M_AW-1:0] k_q, k_d;
    logic            valid_q, valid_d;

    logic [7:0]      f_idx, out_byte;
    logic            last_byte, reject;
    logic [S_AW-1:0] s_addr;
    logic [7:0]      s_data;
    logic            s_wren;
    logic [M_AW-1:0] rom_addr, out_addr;
    logic [7:0]      out_data;
    logic            out_wren;

    assign f_idx     = si_q + sj_q;
    assign out_byte  = mem.s_q ^ mem.rom_q;
    assign last_byte = (k_q == M_AW'(MSG_LEN - 1));

`ifdef RC4_PRGA_CHECK_PRINTABLE_EN
    assign reject = !(((out_byte >= 8'h61) && (out_byte <= 8'h7A)) || (out_byte == 8'h20));
`else
    assign reject = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            valid_q <= valid_d;
        end
    end

    // Wait/latch states keep the read address stable so the memory re-samples the same entry.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        si_d     = si_q;
        sj_d     = sj_q;
        valid_d  = valid_q;
        s_addr   = '0;
        s_data   = '0;
        s_wren   = 1'b0;
        rom_addr = '0;
        out_addr = '0;
        out_data = '0;
        out_wren = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = INC_I;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    valid_d = 1'b0;
                end
            end
            INC_I: begin
                i_d     = i_q + 8'd1;
                state_d = RD_I;
            end
            RD_I: begin
                s_addr  = S_AW'(i_q);
                state_d = WT_I;
            end
            WT_I: begin
                s_addr  = S_AW'(i_q);
                state_d = LT_I;
            end
            LT_I: begin
                s_addr  = S_AW'(i_q);
                si_d    = mem.s_q;
                j_d     = j_q + mem.s_q;
                state_d = RD_J;
            end
            RD_J: begin
                s_addr  = S_AW'(j_q);
                state_d = WT_J;
            end
            WT_J: begin
                s_addr  = S_AW'(j_q);
                state_d = LT_J;
            end
            LT_J: begin
                s_addr  = S_AW'(j_q);
                sj_d    = mem.s_q;
                state_d = WR_I;
            end
            WR_I: begin
                s_addr  = S_AW'(i_q);
                s_data  = sj_q;
                s_wren  = 1'b1;
                state_d = WR_J;
            end
            WR_J: begin
                s_addr  = S_AW'(j_q);
                s_data  = si_q;
                s_wren  = 1'b1;
                state_d = RD_F;
            end
            RD_F, WT_F: begin
                s_addr   = S_AW'(f_idx);
                rom_addr = k_q;
                state_d  = (state_q == RD_F) ? WT_F : WR_O;
            end
            WR_O: begin
                s_addr   = S_AW'(f_idx);
                rom_addr = k_q;
                out_addr = k_q;
                out_data = out_byte;
                out_wren = 1'b1;
                if (last_byte || reject) begin
                    state_d = DONE;
                    valid_d = !reject;
                end else begin
                    k_d     = k_q + M_AW'(1);
                    state_d = INC_I;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q != IDLE) && (state_q != DONE);
    assign done  = (state_q == DONE);
    assign valid = valid_q;

    assign mem.s_addr   = s_addr;
    assign mem.s_data   = s_data;
    assign mem.s_wren   = s_wren;
    assign mem.rom_addr = rom_addr;
    assign mem.out_addr = out_addr;
    assign mem.out_data = out_data;
    assign mem.out_wren = out_wren;
endmodule
